// File: rtl/seq_signed_divider.sv
// Iterative radix-2 signed divider (restoring). Quotient truncates toward zero and the
// remainder takes the dividend's sign. Fixed latency: valid_out rises WIDTH+1 edges after
// the accept edge, whatever the operands.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   valid_in / in_ready    operand handshake; in_ready is high only while idle
//   A, B                   signed dividend / divisor, sampled on the accept edge
//   valid_out / out_ready  result handshake; results are held until consumed
//   Q, R                   signed quotient / remainder
//   div_by_zero, overflow  special-case flags qualified by valid_out
module seq_signed_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             valid_out,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // original dividend, returned as R on divide-by-zero
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;   // |A| shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // |B|
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             bz_q, bz_d;     // B was zero
  logic             ovp_q, ovp_d;   // MIN / -1
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign in_ready    = (state_q == StIdle);
  assign valid_out   = valid_q;
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

  // The remainder always stays below |B| <= 2^(WIDTH-1), so WIDTH+1 bits hold the shifted
  // value and the MSB of diff is a reliable borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    bz_d    = bz_q;
    ovp_d   = ovp_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    valid_d = valid_q;

    case (state_q)
      StIdle: begin
        if (valid_in) begin
          a_d     = A;
          neg_q_d = A[WIDTH-1] ^ B[WIDTH-1];
          neg_r_d = A[WIDTH-1];
          // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
          dvd_d   = A[WIDTH-1] ? -A : A;
          dvs_d   = B[WIDTH-1] ? -B : B;
          rem_d   = '0;
          cnt_d   = '0;
          bz_d    = (B == '0);
          ovp_d   = (A == MinVal) && (B == '1);
          state_d = StCalc;
        end
      end

      StCalc: begin
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (bz_q) begin
          q_d  = '1;
          r_d  = a_q;
          dz_d = 1'b1;
          ov_d = 1'b0;
        end else if (ovp_q) begin
          q_d  = MinVal;
          r_d  = '0;
          dz_d = 1'b0;
          ov_d = 1'b1;
        end else begin
          q_d  = neg_q_q ? -dvd_q : dvd_q;
          r_d  = neg_r_q ? -rem_q : rem_q;
          dz_d = 1'b0;
          ov_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = StDone;
      end

      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bz_q    <= 1'b0;
      ovp_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      bz_q    <= bz_d;
      ovp_q   <= ovp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (WIDTH=32): stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_seq_signed_divider;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         valid_out;
  logic         out_ready;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_by_zero;
  logic         overflow;

  int   checks;
  int   failures;
  bit   rand_stall;
  res_t exp_q[$];

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden model: language signed division plus the two overridden cases.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t t;
    t.dz = 1'b0;
    t.ov = 1'b0;
    if (b == '0) begin
      t.q  = '1;
      t.r  = a;
      t.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      t.q  = a;
      t.r  = '0;
      t.ov = 1'b1;
    end else begin
      t.q = $signed(a) / $signed(b);
      t.r = $signed(a) % $signed(b);
    end
    return t;
  endfunction

  function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input logic ov);
    res_t t;
    t.q  = q;
    t.r  = r;
    t.dz = dz;
    t.ov = ov;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid_out & out_ready.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h required=none", {Q, R, div_by_zero, overflow});
        end else begin
          e = exp_q.pop_front();
          chk("result", {Q, R, div_by_zero, overflow}, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Waits for in_ready, presents the pair for one accept edge; returns 1 unit after that edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                       input res_t e);
    int n;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 1);
    A        = a;
    B        = b;
    valid_in = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    valid_in = 1'b0;
    A        = $urandom;
    B        = $urandom;
  endtask

  // Called 1 unit after the accept edge with out_ready=1.
  task automatic measure(input string name);
    int n;
    bit ir_bad;
    n      = 0;
    ir_bad = 1'b0;
    while (!valid_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready) ir_bad = 1'b1;
    end
    chk({name, "_latency"}, n, 33);
    chk({name, "_in_ready_busy"}, {31'd0, ir_bad}, 0);
    @(posedge clk);
    #1;
    chk({name, "_after_consume"}, {valid_out, in_ready}, 2'b01);
  endtask

  logic [W-1:0] ta[6];
  logic [W-1:0] tbv[6];
  res_t         te[6];

  initial begin
    res_t e;
    int   n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    checks     = 0;
    failures   = 0;
    rand_stall = 1'b0;
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    out_ready  = 1'b0;
    A          = '0;
    B          = '0;

    #20;
    chk("reset_outputs", {valid_out, Q, R, div_by_zero, overflow}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    issue(32'd20000, 32'd200, 1, mk(32'd100, 32'd0, 1'b0, 1'b0));
    measure("basic");

    ta[0] = -32'sd7;        tbv[0] = 32'sd2;  te[0] = mk(-32'sd3, -32'sd1, 1'b0, 1'b0);
    ta[1] = 32'sd7;         tbv[1] = -32'sd2; te[1] = mk(-32'sd3, 32'sd1, 1'b0, 1'b0);
    ta[2] = -32'sd7;        tbv[2] = -32'sd2; te[2] = mk(32'sd3, -32'sd1, 1'b0, 1'b0);
    ta[3] = 32'h7FFF_FFFF;  tbv[3] = 32'sd2;  te[3] = mk(32'd1073741823, 32'd1, 1'b0, 1'b0);
    ta[4] = 32'd1234;       tbv[4] = 32'd0;   te[4] = mk(32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    ta[5] = 32'h8000_0000;  tbv[5] = -32'sd1; te[5] = mk(32'h8000_0000, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tbv[i], 1, te[i]);
      measure("directed");
    end

    // Backpressure: result must hold and no operand may be taken while stalled.
    out_ready = 1'b0;
    e = mk(-32'sd30, -32'sd10, 1'b0, 1'b0);
    issue(-32'sd1000, 32'sd33, 1, e);
    n = 0;
    while (!valid_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      valid_in = k[0];
      A        = $urandom;
      B        = $urandom;
      @(posedge clk);
      #1;
      chk("stall_hold", {in_ready, valid_out, Q, R}, {1'b0, 1'b1, e.q, e.r});
    end
    A         = 32'd555;
    B         = -32'sd5;
    valid_in  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", {valid_out, in_ready}, 2'b01);
    @(posedge clk);
    exp_q.push_back(mk(-32'sd111, 32'd0, 1'b0, 1'b0));
    #1;
    valid_in = 1'b0;
    chk("accept_after_release", {31'd0, in_ready}, 0);
    measure("post_stall");

    // Asynchronous reset in the middle of CALC.
    issue(32'd100, 32'd7, 0, mk(32'd14, 32'd2, 1'b0, 1'b0));
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {valid_out, Q, R, div_by_zero, overflow}, 0);
    chk("midop_reset_in_ready", {31'd0, in_ready}, 1);
    exp_q.delete();
    #4 rst_n = 1'b1;
    issue(32'd100, 32'd7, 1, mk(32'd14, 32'd2, 1'b0, 1'b0));
    measure("after_reset");

    // Random traffic with consumer stalls and injected corner operands.
    rand_stall = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 10)
        0: rb = '0;
        1: rb = 32'd1;
        2: rb = 32'hFFFF_FFFF;
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: rb = 32'($urandom_range(1, 20));
        5: rb = -32'($urandom_range(1, 20));
        6: ra = 32'h8000_0000;
        default: ;
      endcase
      issue(ra, rb, 1, model(ra, rb));
    end
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    rand_stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
